cpu_decode: RTL and testbench
=============================

// Module: cpu_decode
// PURPOSE
//  Decode stage of the 5-stage 16-bit CPU, directly downstream of CPU_Fetch.
//  - Consumes InstructionD/PCD; reads the 16x16 register file; generates control and sign-extended immediate.
//  - Registers everything into the D/E pipeline register for Execute.
//  - Hosts the architectural register file, written back from WB.
// PARAMETERS
//  WIDTH            16  datapath / PC width
//  REGNUM           16  number of registers
//  ADDRESSWIDTH     4   register index width
//  OPCODEWIDTH      4   opcode field width
//  INSTRUCTIONWIDTH 24  instruction width
// PORTS
//  clk           in   1       clock, rising edge
//  reset         in   1       asynchronous, active-high
//  InstructionD  in   24      instruction from F/D register
//  PCD           in   WIDTH   PC of InstructionD
//  RegWriteW     in   1       writeback enable
//  WriteRegW     in   4       writeback register index
//  ResultW       in   WIDTH   writeback data
//  stallE        in   1       hold D/E register
//  flushE        in   1       load bubble into D/E register
//  Rs1D, Rs2D    out  4       source indices (combinational, to hazard unit)
//  RD1E, RD2E    out  WIDTH   registered operands
//  ImmE          out  WIDTH   registered sign-extended immediate
//  Rs1E, Rs2E    out  4       registered source indices (forwarding)
//  RdE           out  4       registered destination index
//  PCE           out  WIDTH   registered PC
//  RegWriteE, MemWriteE, MemToRegE, ALUSrcE, BranchE, BranchNeE, JumpE, HaltE  out 1 each
//  ALUControlE   out  4       registered ALU operation
// BEHAVIOUR
//  Format: [23:20] op, [19:16] rd, [15:12] rs1, [11:8] rs2, [11:0] imm12 (sign-extended to 16).
//  Opcodes:
//   - 0 NOP; 1 ADD; 2 SUB; 3 MUL; 4 AND; 5 OR; 6 XOR; 7 SHL; 8 SHR: R-type, RegWrite=1, ALUSrc=0.
//   - 9 ADDI: RegWrite, ALUSrc.
//   - A LOAD rd <- M[rs1+imm]: RegWrite, ALUSrc, MemToReg.
//   - B STORE M[rs1+imm] <- rd: MemWrite, ALUSrc; Rs2D = rd field.
//   - C BEQ / D BNE rs1 vs rd, target PC+imm: Branch (D also BranchNe); Rs2D = rd field.
//   - E JMP PC+imm: Jump.
//   - F HALT: HaltE.
//  ALUControl = opcode for 1..8; ADD (1) for 9/A/B; SUB (2) for C/D; 0 otherwise.
//  All control bits 0 for NOP; all-zero instruction is a NOP (matches fetch flush value).
//  Register file:
//   - R0 hardwired 0; writes to R0 ignored.
//   - Written on rising clk when RegWriteW.
//   - Read is write-through: if RegWriteW && WriteRegW==Rs && Rs!=0, RD returns ResultW the same cycle.
//  D/E register, per rising clk, priority order:
//   - reset (async): all E outputs 0, all registers 0.
//   - flushE: all E outputs 0 (bubble); flushE beats stallE.
//   - stallE: hold.
//   - otherwise: load decoded values.
//  Latency: decode-to-E outputs 1 cycle. Rs1D/Rs2D are combinational, 0 latency.
//  Regfile writes proceed during stallE/flushE; reset mid-operation clears everything next cycle onward.
//  Immediate arithmetic: ImmE = {{4{imm12[11]}}, imm12}; no overflow logic in this stage.
// STRUCTURE
//  cpu_pkg:
//   - opcode enum, widths.
//   - ctrl_t packed struct {RegWrite, MemWrite, MemToReg, ALUSrc, Branch, BranchNe, Jump, Halt, ALUControl[3:0]}.
//   - CTRL_NOP constant.
//  Sub-module cpu_regfile: 16x16, async reset, 1 write port, 2 write-through read ports.
//  Decoder is a combinational case inside cpu_decode.
// TESTING
//  1. Reset pulse -> all E outputs 0; reading R1..R15 gives 0.
//  2. Write R3=16'h00A5 via WB; then ADD R1,R3,R0 (24'h113000) -> next cycle RD1E=00A5, RD2E=0,
//     RdE=1, RegWriteE=1, ALUControlE=1.
//  3. Same-cycle bypass: RegWriteW=1, WriteRegW=4, ResultW=16'h1234 while decoding rs1=4 -> RD1E=1234.
//     Same with WriteRegW=0 -> RD1E=0.
//  4. ADDI R2,R0,-1 (24'h920FFF) -> ImmE=16'hFFFF, ALUSrcE=1.
//     LOAD (24'hA21004) -> MemToRegE=1, ImmE=4.
//  5. stallE=1 for 2 cycles -> E outputs held.
//     flushE=1 && stallE=1 -> all E outputs 0.
//     Next cycle, no stall/flush -> current decode loaded.
//  6. BEQ R5,R6,+3 (24'hC56003) -> BranchE=1, BranchNeE=0, ALUControlE=2, Rs2E=5, PCE=PCD.
//     HALT (24'hF00000) -> HaltE=1, all other control 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit five-stage CPU.
package cpu_pkg;

  localparam int WIDTH            = 16;
  localparam int REGNUM           = 16;
  localparam int ADDRESSWIDTH     = 4;
  localparam int OPCODEWIDTH      = 4;
  localparam int INSTRUCTIONWIDTH = 24;

  typedef enum logic [OPCODEWIDTH-1:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_MUL   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_SHL   = 4'h7,
    OP_SHR   = 4'h8,
    OP_ADDI  = 4'h9,
    OP_LOAD  = 4'hA,
    OP_STORE = 4'hB,
    OP_BEQ   = 4'hC,
    OP_BNE   = 4'hD,
    OP_JMP   = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef struct packed {
    logic       RegWrite;
    logic       MemWrite;
    logic       MemToReg;
    logic       ALUSrc;
    logic       Branch;
    logic       BranchNe;
    logic       Jump;
    logic       Halt;
    logic [3:0] ALUControl;
  } ctrl_t;

  // Bubble value: no architectural side effects downstream.
  localparam ctrl_t CTRL_NOP = '0;

  // The 12-bit immediate field is two's complement.
  function automatic logic [WIDTH-1:0] signExtend12(input logic [11:0] imm);
    return {{(WIDTH-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Architectural register file: 16x16, R0 hardwired to zero, one write port
// from writeback and two read ports that bypass a same-cycle write.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    writeEnable,
  input  logic [ADDRESSWIDTH-1:0] writeAddr,
  input  logic [WIDTH-1:0]        writeData,
  input  logic [ADDRESSWIDTH-1:0] readAddr1,
  output logic [WIDTH-1:0]        readData1,
  input  logic [ADDRESSWIDTH-1:0] readAddr2,
  output logic [WIDTH-1:0]        readData2
);

  logic [WIDTH-1:0] regs [REGNUM];

  // Storage update: clear on reset, otherwise write any register except R0.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: reset clears every entry so a mid-run reset leaves no stale
    // operands; state uses <= so reads in the same edge see the old value.
    if (reset) begin
      for (int i = 0; i < REGNUM; i++) regs[i] <= '0;
    end else if (writeEnable && writeAddr != '0) begin
      regs[writeAddr] <= writeData;
    end
  end

  // Read ports: R0 reads zero, a same-cycle write to the addressed register wins.
  always_comb begin
    readData1 = regs[readAddr1];
    readData2 = regs[readAddr2];
    if (readAddr1 == '0)                                readData1 = '0;
    else if (writeEnable && writeAddr == readAddr1)     readData1 = writeData;
    if (readAddr2 == '0)                                readData2 = '0;
    else if (writeEnable && writeAddr == readAddr2)     readData2 = writeData;
  end

endmodule

// File: rtl/cpu_decode.sv
// Decode stage: splits the instruction, reads operands, generates control
// and the sign-extended immediate, and registers all of it into D/E.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [INSTRUCTIONWIDTH-1:0] InstructionD,
  input  logic [WIDTH-1:0]            PCD,
  input  logic                        RegWriteW,
  input  logic [ADDRESSWIDTH-1:0]     WriteRegW,
  input  logic [WIDTH-1:0]            ResultW,
  input  logic                        stallE,
  input  logic                        flushE,
  output logic [ADDRESSWIDTH-1:0]     Rs1D,
  output logic [ADDRESSWIDTH-1:0]     Rs2D,
  output logic [WIDTH-1:0]            RD1E,
  output logic [WIDTH-1:0]            RD2E,
  output logic [WIDTH-1:0]            ImmE,
  output logic [ADDRESSWIDTH-1:0]     Rs1E,
  output logic [ADDRESSWIDTH-1:0]     Rs2E,
  output logic [ADDRESSWIDTH-1:0]     RdE,
  output logic [WIDTH-1:0]            PCE,
  output logic                        RegWriteE,
  output logic                        MemWriteE,
  output logic                        MemToRegE,
  output logic                        ALUSrcE,
  output logic                        BranchE,
  output logic                        BranchNeE,
  output logic                        JumpE,
  output logic                        HaltE,
  output logic [3:0]                  ALUControlE
);

  opcode_e                 opD;
  logic [ADDRESSWIDTH-1:0] rdD;
  logic [WIDTH-1:0]        rd1D, rd2D, immD;
  ctrl_t                   ctrlD, ctrlE;

  assign opD  = opcode_e'(InstructionD[23:20]);
  assign rdD  = InstructionD[19:16];
  assign Rs1D = InstructionD[15:12];
  // Stores and branches compare/store the rd register, so it rides the second port.
  assign Rs2D = (opD inside {OP_STORE, OP_BEQ, OP_BNE}) ? rdD : InstructionD[11:8];
  assign immD = signExtend12(InstructionD[11:0]);

  cpu_regfile u_regfile (
    .clk         (clk),
    .reset       (reset),
    .writeEnable (RegWriteW),
    .writeAddr   (WriteRegW),
    .writeData   (ResultW),
    .readAddr1   (Rs1D),
    .readData1   (rd1D),
    .readAddr2   (Rs2D),
    .readData2   (rd2D)
  );

  // Control decoder: opcode to control bundle.
  always_comb begin
    // NOTE: default first so every path assigns ctrlD and no latch is inferred.
    ctrlD = CTRL_NOP;
    case (opD)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
        ctrlD.RegWrite   = 1'b1;
        ctrlD.ALUControl = opD;
      end
      OP_ADDI: begin
        ctrlD.RegWrite   = 1'b1;
        ctrlD.ALUSrc     = 1'b1;
        ctrlD.ALUControl = OP_ADD;
      end
      OP_LOAD: begin
        ctrlD.RegWrite   = 1'b1;
        ctrlD.ALUSrc     = 1'b1;
        ctrlD.MemToReg   = 1'b1;
        ctrlD.ALUControl = OP_ADD;
      end
      OP_STORE: begin
        ctrlD.MemWrite   = 1'b1;
        ctrlD.ALUSrc     = 1'b1;
        ctrlD.ALUControl = OP_ADD;
      end
      OP_BEQ: begin
        ctrlD.Branch     = 1'b1;
        ctrlD.ALUControl = OP_SUB;
      end
      OP_BNE: begin
        ctrlD.Branch     = 1'b1;
        ctrlD.BranchNe   = 1'b1;
        ctrlD.ALUControl = OP_SUB;
      end
      OP_JMP:  ctrlD.Jump = 1'b1;
      OP_HALT: ctrlD.Halt = 1'b1;
      default: ;
    endcase
  end

  // D/E pipeline register: reset, then flush (bubble) over stall (hold) over load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flushE) begin
      ctrlE <= CTRL_NOP;
      RD1E  <= '0;
      RD2E  <= '0;
      ImmE  <= '0;
      Rs1E  <= '0;
      Rs2E  <= '0;
      RdE   <= '0;
      PCE   <= '0;
    end else if (!stallE) begin
      ctrlE <= ctrlD;
      RD1E  <= rd1D;
      RD2E  <= rd2D;
      ImmE  <= immD;
      Rs1E  <= Rs1D;
      Rs2E  <= Rs2D;
      RdE   <= rdD;
      PCE   <= PCD;
    end
  end

  assign RegWriteE   = ctrlE.RegWrite;
  assign MemWriteE   = ctrlE.MemWrite;
  assign MemToRegE   = ctrlE.MemToReg;
  assign ALUSrcE     = ctrlE.ALUSrc;
  assign BranchE     = ctrlE.Branch;
  assign BranchNeE   = ctrlE.BranchNe;
  assign JumpE       = ctrlE.Jump;
  assign HaltE       = ctrlE.Halt;
  assign ALUControlE = ctrlE.ALUControl;

endmodule

// File: tb/tb_cpu_decode.sv
// Directed bench for the decode stage with hand-computed expectations.
module tb_cpu_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] InstructionD;
  logic [15:0] PCD;
  logic        RegWriteW;
  logic [3:0]  WriteRegW;
  logic [15:0] ResultW;
  logic        stallE, flushE;
  logic [3:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic [15:0] RD1E, RD2E, ImmE, PCE;
  logic        RegWriteE, MemWriteE, MemToRegE, ALUSrcE, BranchE, BranchNeE, JumpE, HaltE;
  logic [3:0]  ALUControlE;

  int checks = 0;
  int errors = 0;

  // Control order: RegWrite MemWrite MemToReg ALUSrc Branch BranchNe Jump Halt ALUControl[3:0]
  logic [11:0] ctrlBits;
  assign ctrlBits = {RegWriteE, MemWriteE, MemToRegE, ALUSrcE, BranchE, BranchNeE,
                     JumpE, HaltE, ALUControlE};

  cpu_decode dut (
    .clk(clk), .reset(reset), .InstructionD(InstructionD), .PCD(PCD),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .stallE(stallE), .flushE(flushE), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RD1E(RD1E), .RD2E(RD2E), .ImmE(ImmE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .PCE(PCE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemToRegE(MemToRegE),
    .ALUSrcE(ALUSrcE), .BranchE(BranchE), .BranchNeE(BranchNeE), .JumpE(JumpE),
    .HaltE(HaltE), .ALUControlE(ALUControlE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Snapshot of E outputs for the hold check.
  logic [15:0] heldRD1, heldImm, heldPC;
  logic [11:0] heldCtrl;
  logic [3:0]  idx;

  initial begin
    reset = 1'b1; InstructionD = '0; PCD = '0; RegWriteW = 1'b0; WriteRegW = '0;
    ResultW = '0; stallE = 1'b0; flushE = 1'b0;
    #12;
    // 1. Reset state
    check("rst_ctrl", {20'd0, ctrlBits}, 32'h0);
    check("rst_rd1", {16'd0, RD1E}, 32'h0);
    check("rst_pc", {16'd0, PCE}, 32'h0);
    @(negedge clk); reset = 1'b0;
    for (int i = 1; i < 16; i++) begin
      idx = i[3:0];
      InstructionD = {4'h1, 4'h0, idx, 4'h0, 8'h00};
      tick();
      check("rst_regs", {16'd0, RD1E}, 32'h0);
    end

    // 2. Write R3 via WB, then ADD R1,R3,R0
    InstructionD = 24'h000000; RegWriteW = 1'b1; WriteRegW = 4'd3; ResultW = 16'h00A5;
    tick();
    RegWriteW = 1'b0; InstructionD = 24'h113000; PCD = 16'h0010;
    #1 check("rs1d_comb", {28'd0, Rs1D}, 32'd3);
    tick();
    check("add_rd1", {16'd0, RD1E}, 32'h00A5);
    check("add_rd2", {16'd0, RD2E}, 32'h0);
    check("add_rd", {28'd0, RdE}, 32'd1);
    check("add_rs1e", {28'd0, Rs1E}, 32'd3);
    check("add_ctrl", {20'd0, ctrlBits}, 32'h801);
    check("add_pc", {16'd0, PCE}, 32'h0010);

    // 3. Same-cycle bypass, then persistence, then write to R0 ignored
    RegWriteW = 1'b1; WriteRegW = 4'd4; ResultW = 16'h1234; InstructionD = 24'h114000;
    tick();
    check("bypass_r4", {16'd0, RD1E}, 32'h1234);
    RegWriteW = 1'b0;
    tick();
    check("r4_stored", {16'd0, RD1E}, 32'h1234);
    RegWriteW = 1'b1; WriteRegW = 4'd0; ResultW = 16'hBEEF; InstructionD = 24'h110000;
    tick();
    check("bypass_r0", {16'd0, RD1E}, 32'h0);
    RegWriteW = 1'b0;
    tick();
    check("r0_zero", {16'd0, RD1E}, 32'h0);

    // 4. ADDI R2,R0,-1 and LOAD
    InstructionD = 24'h920FFF; PCD = 16'h0020;
    tick();
    check("addi_imm", {16'd0, ImmE}, 32'hFFFF);
    check("addi_ctrl", {20'd0, ctrlBits}, 32'h901);

    // 5. Stall two cycles (regfile write R7 proceeds), then flush+stall, then load
    heldRD1 = RD1E; heldImm = ImmE; heldPC = PCE; heldCtrl = ctrlBits;
    stallE = 1'b1; InstructionD = 24'hA21004; PCD = 16'h0024;
    RegWriteW = 1'b1; WriteRegW = 4'd7; ResultW = 16'h7777;
    tick();
    RegWriteW = 1'b0;
    tick();
    check("stall_imm", {16'd0, ImmE}, 32'hFFFF);
    check("stall_pc", {16'd0, PCE}, 32'h0020);
    check("stall_ctrl", {20'd0, ctrlBits}, 32'h901);
    flushE = 1'b1;
    tick();
    check("flush_ctrl", {20'd0, ctrlBits}, 32'h0);
    check("flush_imm", {16'd0, ImmE}, 32'h0);
    check("flush_pc", {16'd0, PCE}, 32'h0);
    check("flush_rd", {28'd0, RdE}, 32'h0);
    flushE = 1'b0; stallE = 1'b0;
    tick();
    check("load_ctrl", {20'd0, ctrlBits}, 32'hB01);
    check("load_imm", {16'd0, ImmE}, 32'h0004);
    check("load_rd", {28'd0, RdE}, 32'd2);
    check("load_pc", {16'd0, PCE}, 32'h0024);
    InstructionD = 24'h117000;
    tick();
    check("stall_wb_r7", {16'd0, RD1E}, 32'h7777);

    // STORE R3 -> M[R4+5]: second port reads rd
    InstructionD = 24'hB34005;
    #1 check("store_rs2d", {28'd0, Rs2D}, 32'd3);
    tick();
    check("store_ctrl", {20'd0, ctrlBits}, 32'h501);
    check("store_rd2", {16'd0, RD2E}, 32'h00A5);
    check("store_rd1", {16'd0, RD1E}, 32'h1234);

    // 6. BEQ R5,R6,+3 ; BNE ; JMP ; HALT
    InstructionD = 24'hC56003; PCD = 16'h0040;
    tick();
    check("beq_ctrl", {20'd0, ctrlBits}, 32'h082);
    check("beq_rs2e", {28'd0, Rs2E}, 32'd5);
    check("beq_rs1e", {28'd0, Rs1E}, 32'd6);
    check("beq_pc", {16'd0, PCE}, 32'h0040);
    check("beq_imm", {16'd0, ImmE}, 32'h0003);
    InstructionD = 24'hD56800;
    tick();
    check("bne_ctrl", {20'd0, ctrlBits}, 32'h0C2);
    check("bne_imm", {16'd0, ImmE}, 32'hF800);
    InstructionD = 24'hE00FFE;
    tick();
    check("jmp_ctrl", {20'd0, ctrlBits}, 32'h020);
    check("jmp_imm", {16'd0, ImmE}, 32'hFFFE);
    InstructionD = 24'hF00000;
    tick();
    check("halt_ctrl", {20'd0, ctrlBits}, 32'h010);
    InstructionD = 24'h7A1200;
    tick();
    check("shl_ctrl", {20'd0, ctrlBits}, 32'h807);
    InstructionD = 24'h000000;
    tick();
    check("nop_ctrl", {20'd0, ctrlBits}, 32'h000);

    // Async reset mid-operation clears E outputs and the register file
    InstructionD = 24'h113000;
    tick();
    check("pre_rst_rd1", {16'd0, RD1E}, 32'h00A5);
    #2 reset = 1'b1;
    #1 check("async_rst_rd1", {16'd0, RD1E}, 32'h0);
    check("async_rst_ctrl", {20'd0, ctrlBits}, 32'h0);
    @(negedge clk); reset = 1'b0;
    tick();
    check("rst_clears_r3", {16'd0, RD1E}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
